n64_pi_master: RTL and testbench

- PI bus initiator: drives the cartridge-side AD16 bus exactly as the console does, i.e. the other end of the protocol our cart responder decodes.
- Used as a bench/bring-up master on the dev board, so N64DevCartMain can be exercised without a console.
- Accepts burst read/write commands on a valid/ready interface.
- Emits the ALE_H/ALE_L address phases and READ_N/WRITE_N strobes; returns read halfwords on a stream.

---
 rtl/n64_pi_master.sv | 179 +++++++++++++++++
 tb/tb_n64_pi_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_pi_master.sv
// N64 PI bus initiator: drives AD16 address phases and read/write strobes
// for burst commands, returning read halfwords on a pulse stream.
module n64_pi_master #(
  parameter int T_ALE = 2,
  parameter int T_LAT = 8,
  parameter int T_PW  = 4,
  parameter int T_GAP = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic [15:0] pi_ad_o,
  output logic        pi_ad_oe,
  input  logic [15:0] pi_ad_i,
  output logic        pi_ale_h,
  output logic        pi_ale_l,
  output logic        pi_read_n,
  output logic        pi_write_n
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR_HI = 3'd1;
  localparam logic [2:0] ADDR_LO = 3'd2;
  localparam logic [2:0] LATENCY = 3'd3;
  localparam logic [2:0] WAIT_WD = 3'd4;
  localparam logic [2:0] STROBE  = 3'd5;
  localparam logic [2:0] GAP     = 3'd6;

  localparam logic [7:0] C_ALE = 8'(T_ALE - 1);
  localparam logic [7:0] C_LAT = 8'(T_LAT - 1);
  localparam logic [7:0] C_PW  = 8'(T_PW - 1);
  localparam logic [7:0] C_GAP = 8'(T_GAP - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [31:0] addr;
  logic [31:0] naddr;
  logic [8:0]  rem;
  logic        wr;

  assign naddr = addr + 32'd2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr        <= '0;
      rem         <= '0;
      wr          <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      wdata_ready <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      pi_ad_o     <= '0;
      pi_ad_oe    <= 1'b0;
      pi_ale_h    <= 1'b0;
      pi_ale_l    <= 1'b0;
      pi_read_n   <= 1'b1;
      pi_write_n  <= 1'b1;
    end else begin
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr & ~32'd1;
            rem       <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
            wr        <= cmd_write;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            pi_ale_h  <= 1'b1;
            pi_ale_l  <= 1'b1;
            pi_ad_oe  <= 1'b1;
            pi_ad_o   <= cmd_addr[31:16];
            cnt       <= C_ALE;
            state     <= ADDR_HI;
          end
        end
        ADDR_HI: begin
          if (cnt == 8'd0) begin
            pi_ale_h <= 1'b0;
            pi_ad_o  <= addr[15:0];
            cnt      <= C_ALE;
            state    <= ADDR_LO;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ADDR_LO: begin
          if (cnt == 8'd0) begin
            pi_ale_l <= 1'b0;
            pi_ad_oe <= wr;
            cnt      <= C_LAT;
            state    <= LATENCY;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LATENCY: begin
          if (cnt == 8'd0) begin
            if (wr) begin
              state <= WAIT_WD;
            end else begin
              pi_read_n <= 1'b0;
              cnt       <= C_PW;
              state     <= STROBE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WAIT_WD: begin
          if (wdata_valid) begin
            pi_ad_o     <= wdata;
            wdata_ready <= 1'b1;
            pi_write_n  <= 1'b0;
            cnt         <= C_PW;
            state       <= STROBE;
          end
        end
        STROBE: begin
          if (cnt == 8'd0) begin
            pi_read_n  <= 1'b1;
            pi_write_n <= 1'b1;
            if (!wr) begin
              rdata       <= pi_ad_i;
              rdata_valid <= 1'b1;
            end
            cnt   <= C_GAP;
            state <= GAP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            addr <= naddr;
            rem  <= rem - 9'd1;
            if (rem == 9'd1) begin
              pi_ad_oe  <= 1'b0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else if (naddr[8:0] == 9'd0) begin
              // page crossing: the cart needs a fresh address phase
              pi_ale_h <= 1'b1;
              pi_ale_l <= 1'b1;
              pi_ad_oe <= 1'b1;
              pi_ad_o  <= naddr[31:16];
              cnt      <= C_ALE;
              state    <= ADDR_HI;
            end else if (wr) begin
              state <= WAIT_WD;
            end else begin
              pi_read_n <= 1'b0;
              cnt       <= C_PW;
              state     <= STROBE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_pi_master.sv
// Directed bench for n64_pi_master with a small cart-side address model
// that answers reads with the low half of the decoded byte address.
module tb_n64_pi_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic [15:0] pi_ad_o;
  logic        pi_ad_oe;
  logic [15:0] pi_ad_i;
  logic        pi_ale_h;
  logic        pi_ale_l;
  logic        pi_read_n;
  logic        pi_write_n;

  int n_cmp = 0;
  int n_err = 0;

  n64_pi_master dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
    .pi_ad_o(pi_ad_o), .pi_ad_oe(pi_ad_oe), .pi_ad_i(pi_ad_i),
    .pi_ale_h(pi_ale_h), .pi_ale_l(pi_ale_l),
    .pi_read_n(pi_read_n), .pi_write_n(pi_write_n)
  );

  always #5 clock = ~clock;

  int          rd_str = 0;
  int          wr_str = 0;
  int          wr_rdy = 0;
  int          viol = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  logic [15:0] ahi_q[$];
  logic [15:0] alo_q[$];
  logic        p_rn = 1'b1;
  logic        p_wn = 1'b1;
  logic        p_ah = 1'b0;
  logic [31:0] cart = '0;
  logic        fixed = 1'b1;

  always_comb pi_ad_i = fixed ? 16'hBEEF : cart[15:0];

  always @(negedge clock) begin
    if (!pi_read_n && !pi_write_n) viol++;
    if (pi_ale_h && !pi_ale_l) viol++;
    if (busy == cmd_ready) viol++;
    if (p_rn && !pi_read_n) rd_str++;
    if (p_wn && !pi_write_n) begin
      wr_str++;
      wr_q.push_back(pi_ad_o);
    end
    if (!p_rn && pi_read_n) cart = cart + 32'd2;
    if (rdata_valid) rd_q.push_back(rdata);
    if (wdata_ready) wr_rdy++;
    if (pi_ale_h && !p_ah) ahi_q.push_back(pi_ad_o);
    if (!pi_ale_h && p_ah && pi_ale_l) alo_q.push_back(pi_ad_o);
    if (pi_ale_h) cart[31:16] = pi_ad_o;
    else if (pi_ale_l) cart[15:0] = pi_ad_o;
    p_rn = pi_read_n;
    p_wn = pi_write_n;
    p_ah = pi_ale_h;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [7:0] l);
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      @(negedge clock);
      k++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_wrdy(input string tag);
    int k = 0;
    @(negedge clock);
    while (!wdata_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    check(tag, wdata_ready, 1'b1);
  endtask

  int b_rs, b_ws, b_wr, b_rq, b_wq, b_ah, b_al, bad, k;

  initial begin
    repeat (3) @(negedge clock);
    check("rst cmd_ready", cmd_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst read_n", pi_read_n, 1'b1);
    check("rst write_n", pi_write_n, 1'b1);
    check("rst ale", {pi_ale_h, pi_ale_l, pi_ad_oe}, 3'b000);
    check("rst ad_o", pi_ad_o, 16'h0000);
    check("rst rdata", {rdata_valid, wdata_ready, rdata}, 18'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // single read, cycle-exact
    fixed = 1'b1;
    issue(1'b0, 32'h1000_0000, 8'd1);
    check("c1 ale", {pi_ale_h, pi_ale_l, pi_ad_oe}, 3'b111);
    check("c1 ad", pi_ad_o, 16'h1000);
    check("c1 busy", {busy, cmd_ready}, 2'b10);
    @(negedge clock);
    check("c2 ale", {pi_ale_h, pi_ale_l}, 2'b11);
    @(negedge clock);
    check("c3 ale", {pi_ale_h, pi_ale_l}, 2'b01);
    check("c3 ad", pi_ad_o, 16'h0000);
    @(negedge clock);
    check("c4 ale", {pi_ale_h, pi_ale_l}, 2'b01);
    @(negedge clock);
    check("c5 lat", {pi_ale_l, pi_ad_oe, pi_read_n}, 3'b001);
    repeat (7) @(negedge clock);
    check("c12 lat", pi_read_n, 1'b1);
    @(negedge clock);
    check("c13 strobe", pi_read_n, 1'b0);
    repeat (3) @(negedge clock);
    check("c16 strobe", pi_read_n, 1'b0);
    @(negedge clock);
    check("c17 rise", {pi_read_n, rdata_valid}, 2'b11);
    check("c17 rdata", rdata, 16'hBEEF);
    @(negedge clock);
    check("c18 gap", {rdata_valid, busy}, 2'b01);
    @(negedge clock);
    check("c19 idle", {busy, cmd_ready}, 2'b01);

    // read burst across a 512-byte page
    fixed = 1'b0;
    b_rs = rd_str; b_rq = rd_q.size(); b_ah = ahi_q.size(); b_al = alo_q.size();
    issue(1'b0, 32'h1000_01F8, 8'd8);
    wait_idle("burst done", 400);
    check("burst strobes", rd_str - b_rs, 8);
    check("burst rvalid", rd_q.size() - b_rq, 8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (rd_q[b_rq + i] !== 16'(16'h01F8 + 2 * i)) bad++;
    check("burst rdata", bad, 0);
    check("burst hi phases", ahi_q.size() - b_ah, 2);
    check("burst hi reissue", ahi_q[b_ah + 1], 16'h1000);
    check("burst lo first", alo_q[b_al], 16'h01F8);
    check("burst lo reissue", alo_q[b_al + 1], 16'h0200);

    // write burst with a stalled second word
    b_ws = wr_str; b_wr = wr_rdy; b_wq = wr_q.size();
    wdata = 16'h1111;
    wdata_valid = 1'b1;
    issue(1'b1, 32'h1000_0100, 8'd3);
    wait_wrdy("wr rdy1");
    wdata_valid = 1'b0;
    wdata = 16'h2222;
    repeat (10) @(negedge clock);
    check("stall write_n", pi_write_n, 1'b1);
    check("stall oe busy", {pi_ad_oe, busy}, 2'b11);
    check("stall strobes", wr_str - b_ws, 1);
    wdata_valid = 1'b1;
    wait_wrdy("wr rdy2");
    wdata = 16'h3333;
    wait_wrdy("wr rdy3");
    wdata_valid = 1'b0;
    wait_idle("wr done", 200);
    check("wr strobes", wr_str - b_ws, 3);
    check("wr ready pulses", wr_rdy - b_wr, 3);
    check("wr ad0", wr_q[b_wq], 16'h1111);
    check("wr ad1", wr_q[b_wq + 1], 16'h2222);
    check("wr ad2", wr_q[b_wq + 2], 16'h3333);

    // len=0 runs 256 halfwords
    b_rs = rd_str; b_rq = rd_q.size();
    issue(1'b0, 32'h1000_0000, 8'd0);
    wait_idle("len0 done", 4000);
    check("len0 strobes", rd_str - b_rs, 256);
    check("len0 rvalid", rd_q.size() - b_rq, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (rd_q[b_rq + i] !== 16'(2 * i)) bad++;
    check("len0 rdata", bad, 0);

    // back-to-back with cmd_valid held
    fixed = 1'b1;
    b_rs = rd_str;
    cmd_write = 1'b0;
    cmd_addr = 32'h1000_0000;
    cmd_len = 8'd1;
    cmd_valid = 1'b1;
    @(negedge clock);
    check("b2b held off", {busy, cmd_ready}, 2'b10);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("b2b idle gap", {busy, cmd_ready}, 2'b01);
    @(negedge clock);
    check("b2b second", {busy, pi_ale_h}, 2'b11);
    cmd_valid = 1'b0;
    wait_idle("b2b done", 100);
    check("b2b strobes", rd_str - b_rs, 2);

    // async reset mid-strobe
    issue(1'b0, 32'h1000_0000, 8'd4);
    k = 0;
    while (pi_read_n && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("pre-reset strobe", pi_read_n, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("arst read_n", pi_read_n, 1'b1);
    check("arst oe ale", {pi_ad_oe, pi_ale_h, pi_ale_l}, 3'b000);
    check("arst busy", {busy, cmd_ready}, 2'b01);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("post-reset idle", {busy, pi_read_n}, 2'b01);

    check("invariants", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
